// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared size encodings, FSM states and width defaults for the data-memory access controller
package dmem_ctrl_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int XLEN_DEF   = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        ISSUE1,
        DRAIN,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: turns four captured little-endian bytes into a sign- or zero-extended load result
module dmem_load_align
    import dmem_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     bytes_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data_o
);

    logic [31:0] ext;

    // Byte and half results extend from their top bit unless unsigned; word and size 11 pass through
    always_comb begin
        ext    = size_i == SZ_B ? {{24{~unsigned_i & bytes_i[7]}}, bytes_i[7:0]} :
                 size_i == SZ_H ? {{16{~unsigned_i & bytes_i[15]}}, bytes_i[15:0]} :
                 bytes_i;
        data_o = XLEN'(ext);
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: splits MEM-stage loads/stores into even/odd byte beats on a dual-port byte RAM
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int XLEN   = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_a_o,
    output logic [ADDR_W-1:0] ram_addr_b_o,
    output logic [7:0]        ram_wdata_a_o,
    output logic [7:0]        ram_wdata_b_o,
    output logic              ram_we_a_o,
    output logic              ram_we_b_o,
    input  logic [7:0]        ram_rdata_a_i,
    input  logic [7:0]        ram_rdata_b_i
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       rb_q, rb_d;
    logic [XLEN-1:0]   rsp_q, rsp_d;
    logic              is_word, issue, hi;
    logic [31:0]       load_bytes;
    logic [XLEN-1:0]   load_data;

    assign is_word     = size_q >= SZ_W;
    assign req_ready_o = state_q == IDLE;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_rdata_o = rsp_q;

    // In DRAIN the RAM read ports carry the last beat; a word also needs the beat-0 bytes saved in ISSUE1
    assign load_bytes = is_word ? {ram_rdata_b_i, ram_rdata_a_i, rb_q}
                                : {16'h0000, ram_rdata_b_i, ram_rdata_a_i};

    dmem_load_align #(.XLEN(XLEN)) u_align (
        .bytes_i    (load_bytes),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (load_data)
    );

    // State and request registers; reset drops the RAM enables at once because they decode state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rb_q    <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rb_q    <= rb_d;
            rsp_q   <= rsp_d;
        end
    end

    // Sequencing: latch the request in IDLE, step through the beats, build the response on entry to RESP
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rb_d    = rb_q;
        rsp_d   = rsp_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = ISSUE0;
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i[31:0];
                end
            end
            ISSUE0:  state_d = is_word ? ISSUE1 : we_q ? RESP : DRAIN;
            ISSUE1: begin
                state_d = we_q ? RESP : DRAIN;
                rb_d    = {ram_rdata_b_i, ram_rdata_a_i};
            end
            DRAIN:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RESP) rsp_d = we_q ? '0 : load_data;
    end

    // RAM port drive: port A takes even offsets, port B odd; everything is zero outside the issue beats
    always_comb begin
        issue         = state_q == ISSUE0 || state_q == ISSUE1;
        hi            = state_q == ISSUE1;
        ram_addr_a_o  = issue ? addr_q + ADDR_W'({hi, 1'b0}) : '0;
        ram_addr_b_o  = issue ? addr_q + ADDR_W'({hi, 1'b1}) : '0;
        ram_wdata_a_o = issue ? (hi ? wdata_q[23:16] : wdata_q[7:0]) : 8'h00;
        ram_wdata_b_o = issue ? (hi ? wdata_q[31:24] : wdata_q[15:8]) : 8'h00;
        ram_we_a_o    = issue & we_q;
        ram_we_b_o    = issue & we_q & (hi | size_q != SZ_B);
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed vector bench with a byte-wide dual-port RAM model behind the controller
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [14:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [14:0] ram_addr_a_o, ram_addr_b_o;
    logic [7:0]  ram_wdata_a_o, ram_wdata_b_o;
    logic        ram_we_a_o, ram_we_b_o;
    logic [7:0]  ram_rdata_a_i, ram_rdata_b_i;

    logic [7:0]  mem [0:32767];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [14:0] addr;
        logic [7:0]  val;
    } mchk_t;

    vec_t  v [20];
    mchk_t m [14];

    dmem_access_ctrl #(.ADDR_W(15), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .ram_addr_a_o   (ram_addr_a_o),
        .ram_addr_b_o   (ram_addr_b_o),
        .ram_wdata_a_o  (ram_wdata_a_o),
        .ram_wdata_b_o  (ram_wdata_b_o),
        .ram_we_a_o     (ram_we_a_o),
        .ram_we_b_o     (ram_we_b_o),
        .ram_rdata_a_i  (ram_rdata_a_i),
        .ram_rdata_b_i  (ram_rdata_b_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM model: registered read, write-first on the same port
    always @(posedge clk) begin
        if (ram_we_a_o) mem[ram_addr_a_o] <= ram_wdata_a_o;
        if (ram_we_b_o) mem[ram_addr_b_o] <= ram_wdata_b_o;
        ram_rdata_a_i <= ram_we_a_o ? ram_wdata_a_o : mem[ram_addr_a_o];
        ram_rdata_b_i <= ram_we_b_o ? ram_wdata_b_o : mem[ram_addr_b_o];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ram_bus();
        return {ram_addr_a_o, ram_addr_b_o, ram_wdata_a_o, ram_wdata_b_o, ram_we_a_o, ram_we_b_o};
    endfunction

    task automatic run_vec(input vec_t t, input int idx);
        int   cyc;
        logic sa, sb;
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", idx), 64'(req_ready_o), 64'd1);
        req_valid_i    = 1'b1;
        req_we_i       = t.we;
        req_size_i     = t.size;
        req_unsigned_i = t.uns;
        req_addr_i     = t.addr;
        req_wdata_i    = t.wdata;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk($sformatf("v%0d_busy_ready", idx), 64'(req_ready_o), 64'd0);
        cyc = 1;
        sa  = ram_we_a_o;
        sb  = ram_we_b_o;
        while (!rsp_valid_o && cyc < 10) begin
            @(negedge clk);
            cyc++;
            sa |= ram_we_a_o;
            sb |= ram_we_b_o;
        end
        chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(t.lat));
        chk($sformatf("v%0d_rdata", idx), 64'(rsp_rdata_o), 64'(t.exp));
        chk($sformatf("v%0d_we_a_seen", idx), 64'(sa), 64'(t.we));
        chk($sformatf("v%0d_we_b_seen", idx), 64'(sb), 64'(t.we && t.size != 2'b00));
        @(negedge clk);
        chk($sformatf("v%0d_pulse_end", idx), 64'(rsp_valid_o), 64'd0);
        chk($sformatf("v%0d_idle_ram", idx), ram_bus(), 64'd0);
        chk($sformatf("v%0d_rdata_hold", idx), 64'(rsp_rdata_o), 64'(t.exp));
    endtask

    initial begin
        int acc, rsp;
        v[0]  = '{1'b1, 2'd2, 1'b0, 15'h0100, 32'hDEADBEEF, 32'h00000000, 3};
        v[1]  = '{1'b0, 2'd2, 1'b0, 15'h0100, 32'h00000000, 32'hDEADBEEF, 4};
        v[2]  = '{1'b1, 2'd1, 1'b0, 15'h0010, 32'h99887700, 32'h00000000, 2};
        v[3]  = '{1'b1, 2'd0, 1'b0, 15'h0010, 32'h12345680, 32'h00000000, 2};
        v[4]  = '{1'b0, 2'd0, 1'b0, 15'h0010, 32'h00000000, 32'hFFFFFF80, 3};
        v[5]  = '{1'b0, 2'd0, 1'b1, 15'h0010, 32'h00000000, 32'h00000080, 3};
        v[6]  = '{1'b0, 2'd1, 1'b1, 15'h0010, 32'h00000000, 32'h00007780, 3};
        v[7]  = '{1'b0, 2'd1, 1'b0, 15'h0010, 32'h00000000, 32'h00007780, 3};
        v[8]  = '{1'b1, 2'd1, 1'b0, 15'h0021, 32'hAAAA1234, 32'h00000000, 2};
        v[9]  = '{1'b1, 2'd0, 1'b0, 15'h0023, 32'h000000FE, 32'h00000000, 2};
        v[10] = '{1'b0, 2'd1, 1'b0, 15'h0022, 32'h00000000, 32'hFFFFFE12, 3};
        v[11] = '{1'b0, 2'd1, 1'b1, 15'h0022, 32'h00000000, 32'h0000FE12, 3};
        v[12] = '{1'b1, 2'd2, 1'b0, 15'h7FFF, 32'h44332211, 32'h00000000, 3};
        v[13] = '{1'b0, 2'd2, 1'b0, 15'h7FFF, 32'h00000000, 32'h44332211, 4};
        v[14] = '{1'b0, 2'd3, 1'b0, 15'h0100, 32'h00000000, 32'hDEADBEEF, 4};
        v[15] = '{1'b0, 2'd0, 1'b0, 15'h0101, 32'h00000000, 32'hFFFFFFBE, 3};
        v[16] = '{1'b1, 2'd0, 1'b0, 15'h0200, 32'hFFFFFF55, 32'h00000000, 2};
        v[17] = '{1'b0, 2'd2, 1'b1, 15'h0100, 32'h00000000, 32'hDEADBEEF, 4};
        v[18] = '{1'b1, 2'd2, 1'b0, 15'h0300, 32'h00000000, 32'h00000000, 3};
        v[19] = '{1'b0, 2'd1, 1'b0, 15'h0021, 32'h00000000, 32'h00001234, 3};
        m[0]  = '{15'h0100, 8'hEF};
        m[1]  = '{15'h0101, 8'hBE};
        m[2]  = '{15'h0102, 8'hAD};
        m[3]  = '{15'h0103, 8'hDE};
        m[4]  = '{15'h0010, 8'h80};
        m[5]  = '{15'h0011, 8'h77};
        m[6]  = '{15'h0021, 8'h34};
        m[7]  = '{15'h0022, 8'h12};
        m[8]  = '{15'h0023, 8'hFE};
        m[9]  = '{15'h7FFF, 8'h11};
        m[10] = '{15'h0000, 8'h22};
        m[11] = '{15'h0001, 8'h33};
        m[12] = '{15'h0002, 8'h44};
        m[13] = '{15'h0200, 8'h55};

        rst_n          = 1'b0;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = '0;
        req_wdata_i    = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(req_ready_o), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset_rdata", 64'(rsp_rdata_o), 64'd0);
        chk("reset_ram", ram_bus(), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) run_vec(v[i], i);

        for (int i = 0; i < 14; i++)
            chk($sformatf("mem_%0h", m[i].addr), 64'(mem[m[i].addr]), 64'(m[i].val));

        // Request held high: accepts only from IDLE, one pulse per word load (5-cycle period)
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_we_i       = 1'b0;
        req_size_i     = 2'd2;
        req_unsigned_i = 1'b0;
        req_addr_i     = 15'h0100;
        acc = 0;
        rsp = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready_o) acc++;
            if (rsp_valid_o) begin
                rsp++;
                chk($sformatf("b2b_rdata_%0d", rsp), 64'(rsp_rdata_o), 64'hDEADBEEF);
            end
            chk($sformatf("b2b_excl_%0d", i), 64'(req_ready_o & rsp_valid_o), 64'd0);
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        chk("b2b_accepts", 64'(acc), 64'd4);
        chk("b2b_responses", 64'(rsp), 64'd4);
        repeat (2) @(negedge clk);
        chk("b2b_idle_ready", 64'(req_ready_o), 64'd1);

        // Reset during ISSUE1 of a word store: beat 0 lands, beat 1 never does
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_size_i  = 2'd2;
        req_addr_i  = 15'h0300;
        req_wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("mid_we_a_before", 64'(ram_we_a_o), 64'd1);
        chk("mid_addr_a_before", 64'(ram_addr_a_o), 64'h0302);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ram", ram_bus(), 64'd0);
        chk("mid_rst_ready", 64'(req_ready_o), 64'd1);
        chk("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("mid_rst_rdata", 64'(rsp_rdata_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("post_rst_no_rsp_%0d", i), 64'(rsp_valid_o), 64'd0);
            chk($sformatf("post_rst_ready_%0d", i), 64'(req_ready_o), 64'd1);
            @(negedge clk);
        end
        chk("rst_mem_300", 64'(mem[15'h0300]), 64'h0D);
        chk("rst_mem_301", 64'(mem[15'h0301]), 64'hF0);
        chk("rst_mem_302", 64'(mem[15'h0302]), 64'h00);
        chk("rst_mem_303", 64'(mem[15'h0303]), 64'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
